// File: rtl/aclk_keypad_scan_if.sv
// Keypad scanner boundary: matrix lines plus the digit and key-code strobes.
// The master is the scanner; the slave is the keypad and its downstream consumers.
interface aclk_keypad_scan_if;
    logic [3:0] col_in;
    logic [3:0] row_out;
    logic [3:0] key;
    logic       shift;
    logic [3:0] key_code;
    logic       key_strobe;

    modport master (
        input  col_in,
        output row_out, key, shift, key_code, key_strobe
    );

    modport slave (
        output col_in,
        input  row_out, key, shift, key_code, key_strobe
    );
endinterface

// File: rtl/aclk_keypad_scan.sv
// Purpose: 4x4 keypad scanner/debouncer that emits one digit/code pulse per physical press.
// Latency: 2-cycle column sync + DEBOUNCE_CYC+1 stable cycles to pulse; no backpressure, pulses are fire-and-forget.
module aclk_keypad_scan #(
    parameter int SCAN_DIV     = 16,
    parameter int DEBOUNCE_CYC = 1000
) (
    input  logic               clk,
    input  logic               reset,
    aclk_keypad_scan_if.master kp
);
    localparam int MAXV = (SCAN_DIV > DEBOUNCE_CYC) ? SCAN_DIV : DEBOUNCE_CYC;
    localparam int CW   = $clog2(MAXV);
    localparam logic [CW-1:0] DIV_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYC - 1);
    localparam logic [CW-1:0] SYNC_LAT = CW'(2);

    // Indexed by {row, col}; rows r0..r3 top to bottom, cols c0..c3 left to right.
    localparam logic [3:0] KEYMAP [16] = '{
        4'd1,  4'd2, 4'd3,  4'd10,
        4'd4,  4'd5, 4'd6,  4'd11,
        4'd7,  4'd8, 4'd9,  4'd12,
        4'd14, 4'd0, 4'd15, 4'd13
    };

    typedef enum logic [1:0] {SCAN, DEBOUNCE, EMIT, RELEASE} state_t;

    state_t        state, state_nxt;
    logic [3:0]    col_m, col_s;
    logic [1:0]    row_idx, row_nxt;
    logic [CW-1:0] div_cnt, div_nxt;
    logic [CW-1:0] db_cnt, db_nxt;
    logic [3:0]    pat, pat_nxt;
    logic [1:0]    col_idx;
    logic          one_low;
    logic [3:0]    code;
    logic          digit;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic [CW-1:0] lim);
        return (v == lim) ? v : v + 1'b1;
    endfunction

    assign kp.row_out = ~(4'b0001 << row_idx);

    always_comb begin
        one_low = 1'b1;
        col_idx = 2'd0;
        case (pat)
            4'b1110: col_idx = 2'd0;
            4'b1101: col_idx = 2'd1;
            4'b1011: col_idx = 2'd2;
            4'b0111: col_idx = 2'd3;
            default: one_low = 1'b0;
        endcase
        code  = KEYMAP[{row_idx, col_idx}];
        digit = (code <= 4'd9);
    end

    always_comb begin
        state_nxt = state;
        row_nxt   = row_idx;
        div_nxt   = div_cnt;
        db_nxt    = db_cnt;
        pat_nxt   = pat;
        unique case (state)
            SCAN: begin
                // col_s lags a row change by the sync depth, so the first cycles of a row are blind.
                if (div_cnt >= SYNC_LAT && col_s != 4'hF) begin
                    pat_nxt   = col_s;
                    db_nxt    = '0;
                    state_nxt = DEBOUNCE;
                end else if (div_cnt == DIV_LAST) begin
                    div_nxt = '0;
                    row_nxt = row_idx + 2'd1;
                end else begin
                    div_nxt = sat_inc(div_cnt, DIV_LAST);
                end
            end
            DEBOUNCE: begin
                if (col_s != pat) begin
                    div_nxt   = '0;
                    state_nxt = SCAN;
                end else if (db_cnt == DB_LAST) begin
                    db_nxt    = '0;
                    state_nxt = one_low ? EMIT : RELEASE;
                end else begin
                    db_nxt = sat_inc(db_cnt, DB_LAST);
                end
            end
            EMIT: begin
                db_nxt    = '0;
                state_nxt = RELEASE;
            end
            RELEASE: begin
                if (col_s != 4'hF) begin
                    db_nxt = '0;
                end else if (db_cnt == DB_LAST) begin
                    db_nxt    = '0;
                    div_nxt   = '0;
                    state_nxt = SCAN;
                end else begin
                    db_nxt = sat_inc(db_cnt, DB_LAST);
                end
            end
            default: state_nxt = SCAN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_m         <= 4'hF;
            col_s         <= 4'hF;
            state         <= SCAN;
            row_idx       <= 2'd0;
            div_cnt       <= '0;
            db_cnt        <= '0;
            pat           <= 4'hF;
            kp.key        <= 4'd0;
            kp.shift      <= 1'b0;
            kp.key_code   <= 4'd0;
            kp.key_strobe <= 1'b0;
        end else begin
            col_m         <= kp.col_in;
            col_s         <= col_m;
            state         <= state_nxt;
            row_idx       <= row_nxt;
            div_cnt       <= div_nxt;
            db_cnt        <= db_nxt;
            pat           <= pat_nxt;
            // Pulses are registered so they coincide with the single EMIT cycle.
            kp.key_strobe <= (state_nxt == EMIT);
            kp.shift      <= (state_nxt == EMIT) && digit;
            if (state_nxt == EMIT) begin
                kp.key_code <= code;
                if (digit) begin
                    kp.key <= code;
                end
            end
        end
    end
endmodule

// File: tb/tb_aclk_keypad_scan.sv
// Directed bench for the keypad scanner: a physical keypad model feeds col_in from row_out.
module tb_aclk_keypad_scan;
    localparam int SD       = 4;
    localparam int DB       = 20;
    localparam int REL_WAIT = 3 * DB;
    localparam int NV       = 18;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    aclk_keypad_scan_if kp ();

    aclk_keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_CYC(DB)) dut (
        .clk   (clk),
        .reset (reset),
        .kp    (kp)
    );

    // pressed[r][c]: key at row r, column c is held down.
    logic [3:0] pressed [4];
    logic [3:0] col_v;
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            col_v[c] = 1'b1;
            for (int r = 0; r < 4; r++) begin
                if (pressed[r][c] && !kp.row_out[r]) col_v[c] = 1'b0;
            end
        end
    end
    assign kp.col_in = col_v;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Output monitor: pulse totals and protocol violations.
    int shift_tot = 0;
    int strobe_tot = 0;
    int consec_viol = 0;
    int change_viol = 0;
    logic       prev_shift = 1'b0;
    logic       prev_strobe = 1'b0;
    logic [3:0] prev_key = 4'd0;
    logic [3:0] prev_code = 4'd0;
    always @(negedge clk) begin
        if (reset) begin
            prev_shift  = 1'b0;
            prev_strobe = 1'b0;
            prev_key    = kp.key;
            prev_code   = kp.key_code;
        end else begin
            if (kp.shift) shift_tot++;
            if (kp.key_strobe) strobe_tot++;
            if ((kp.shift && prev_shift) || (kp.key_strobe && prev_strobe)) consec_viol++;
            if (kp.key !== prev_key && !kp.shift) change_viol++;
            if (kp.key_code !== prev_code && !kp.key_strobe) change_viol++;
            prev_shift  = kp.shift;
            prev_strobe = kp.key_strobe;
            prev_key    = kp.key;
            prev_code   = kp.key_code;
        end
    end

    task automatic wait_row(input logic [3:0] want, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (kp.row_out == want) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    typedef struct {
        int r;
        int c;
        int c2;
        int hold;
        int exp_shift;
        int exp_strobe;
        int exp_key;
        int exp_code;
    } vec_t;

    vec_t vt [NV];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int s0, t0;
        logic [3:0] exp_row;

        // r, c, second col (-1 none), hold, shifts, strobes, key, key_code
        vt[0]  = '{1, 1, -1, 3*DB,   1, 1, 5, 5};   // '5'
        vt[1]  = '{2, 0, -1, DB/2,   0, 0, 5, 5};   // bounce '7'
        vt[2]  = '{0, 3, -1, 3*DB,   0, 1, 5, 10};  // 'A'
        vt[3]  = '{0, 0,  1, 3*DB,   0, 0, 5, 10};  // '1'+'2' together
        vt[4]  = '{3, 1, -1, 3*DB,   1, 1, 0, 0};   // '0'
        vt[5]  = '{0, 0, -1, 3*DB,   1, 1, 1, 1};   // '1'
        vt[6]  = '{0, 1, -1, 3*DB,   1, 1, 2, 2};   // '2'
        vt[7]  = '{0, 2, -1, 3*DB,   1, 1, 3, 3};   // '3'
        vt[8]  = '{3, 1, -1, 3*DB,   1, 1, 0, 0};   // '0'
        vt[9]  = '{3, 2, -1, 3*DB,   0, 1, 0, 15};  // '#'
        vt[10] = '{3, 0, -1, 3*DB,   0, 1, 0, 14};  // '*'
        vt[11] = '{3, 3, -1, 3*DB,   0, 1, 0, 13};  // 'D'
        vt[12] = '{2, 2, -1, 10*DB,  1, 1, 9, 9};   // '9', long hold
        vt[13] = '{1, 3, -1, 3*DB,   0, 1, 9, 11};  // 'B'
        vt[14] = '{2, 3, -1, 3*DB,   0, 1, 9, 12};  // 'C'
        vt[15] = '{1, 2, -1, 3*DB,   1, 1, 6, 6};   // '6'
        vt[16] = '{2, 1, -1, 3*DB,   1, 1, 8, 8};   // '8'
        vt[17] = '{1, 0, -1, 3*DB,   1, 1, 4, 4};   // '4'

        for (int r = 0; r < 4; r++) pressed[r] = 4'h0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_row_out", int'(kp.row_out), 4'b1110);
        check("reset_key", int'(kp.key), 0);
        check("reset_shift", int'(kp.shift), 0);
        check("reset_key_code", int'(kp.key_code), 0);
        check("reset_key_strobe", int'(kp.key_strobe), 0);

        // Idle rotation: one row step every SD cycles starting from r0.
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            exp_row = ~(4'b0001 << (i % 4));
            check($sformatf("scan_row%0d", i), int'(kp.row_out), int'(exp_row));
            repeat (SD) @(posedge clk);
        end

        for (int i = 0; i < NV; i++) begin
            s0 = shift_tot;
            t0 = strobe_tot;
            @(negedge clk);
            pressed[vt[i].r][vt[i].c] = 1'b1;
            if (vt[i].c2 >= 0) pressed[vt[i].r][vt[i].c2] = 1'b1;
            repeat (vt[i].hold) @(negedge clk);
            pressed[vt[i].r] = 4'h0;
            repeat (REL_WAIT) @(negedge clk);
            check($sformatf("vec%0d_shift_count", i), shift_tot - s0, vt[i].exp_shift);
            check($sformatf("vec%0d_strobe_count", i), strobe_tot - t0, vt[i].exp_strobe);
            check($sformatf("vec%0d_key", i), int'(kp.key), vt[i].exp_key);
            check($sformatf("vec%0d_key_code", i), int'(kp.key_code), vt[i].exp_code);
        end

        // Reset lands DB-2 cycles into the debounce of '9': nothing may be emitted.
        s0 = shift_tot;
        t0 = strobe_tot;
        wait_row(4'b1110, ok);
        check("mid_reset_wait_r0", int'(ok), 1);
        pressed[2][2] = 1'b1;
        wait_row(4'b1011, ok);
        check("mid_reset_wait_r2", int'(ok), 1);
        repeat (DB + 1) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("mid_reset_row_out", int'(kp.row_out), 4'b1110);
        check("mid_reset_key", int'(kp.key), 0);
        check("mid_reset_key_code", int'(kp.key_code), 0);
        check("mid_reset_strobe", int'(kp.key_strobe), 0);
        pressed[2] = 4'h0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (REL_WAIT) @(negedge clk);
        check("mid_reset_shift_count", shift_tot - s0, 0);
        check("mid_reset_strobe_count", strobe_tot - t0, 0);

        check("consecutive_pulse_violations", consec_viol, 0);
        check("unstrobed_change_violations", change_viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
